// File: rtl/aoi_pkg.sv
// aoi_pkg: shared types and helpers for the AOI reduction pipeline.
// Mode encoding, per-pair term and popcount.
package aoi_pkg;

  typedef enum logic [1:0] {
    AOI = 2'd0,
    AO  = 2'd1,
    OAI = 2'd2,
    OA  = 2'd3
  } aoi_mode_t;

  localparam int MAX_PAIRS = 16;
  localparam int MAX_CW    = 5;

  // AND-based modes combine a pair with &, OR-based modes with |.
  function automatic logic pair_term(
    input logic      a,
    input logic      b,
    input aoi_mode_t m
  );
    if (m == AOI || m == AO) begin
      return a & b;
    end
    return a | b;
  endfunction

  function automatic logic [MAX_CW-1:0] popcount(
    input logic [MAX_PAIRS-1:0] v
  );
    logic [MAX_CW-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      c = c + MAX_CW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/aoi_pipe_stage.sv
// aoi_pipe_stage: one valid/ready register slot.
// Loads when empty or when its content leaves this cycle.
module aoi_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_up_valid,
  output logic         o_up_ready,
  input  logic [W-1:0] i_up_data,
  output logic         o_dn_valid,
  input  logic         i_dn_ready,
  output logic [W-1:0] o_dn_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_up_ready = ~r_valid | i_dn_ready;
  assign w_load     = i_up_valid & o_up_ready;
  assign o_dn_valid = r_valid;
  assign o_dn_data  = r_data;

  // Slot register; data only changes on a load so it holds when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (o_up_ready) begin
        r_valid <= i_up_valid;
      end
      if (w_load) begin
        r_data <= i_up_data;
      end
    end
  end

endmodule

// File: rtl/aoi_reduce_pipe.sv
// aoi_reduce_pipe: parametrised AOI/AO/OAI/OA reduction.
// Result is computed at acceptance, then carried by a slot chain.
module aoi_reduce_pipe
  import aoi_pkg::*;
#(
  parameter  int PAIRS  = 2,
  parameter  int STAGES = 2,
  localparam int CW     = $clog2(PAIRS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*PAIRS-1:0] in_data,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out,
  output logic [CW-1:0]      out_pairs
);

  localparam int DW = CW + 1;

  aoi_mode_t              w_mode;
  logic [PAIRS-1:0]       w_t;
  logic [MAX_PAIRS-1:0]   w_t_ext;
  logic [MAX_CW-1:0]      w_cnt;
  logic                   w_res;
  logic [DW-1:0]          w_in_data;

  logic [STAGES:0]        w_valid;
  logic [STAGES:0]        w_ready;
  logic [DW-1:0]          w_data [STAGES+1];

  assign w_mode = aoi_mode_t'(mode);

  // Per-pair terms.
  always_comb begin
    w_t = '0;
    for (int i = 0; i < PAIRS; i++) begin
      w_t[i] = pair_term(in_data[2*i+1], in_data[2*i], w_mode);
    end
  end

  // Zero-extend the terms for the fixed-width popcount.
  always_comb begin
    w_t_ext           = '0;
    w_t_ext[PAIRS-1:0] = w_t;
  end

  assign w_cnt = popcount(w_t_ext);

  // Final reduction selected by mode.
  always_comb begin
    w_res = 1'b0;
    unique case (w_mode)
      AOI:     w_res = ~|w_t;
      AO:      w_res =  |w_t;
      OAI:     w_res = ~&w_t;
      OA:      w_res =  &w_t;
      default: w_res = 1'b0;
    endcase
  end

  assign w_in_data = {w_res, w_cnt[CW-1:0]};

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = w_in_data;
  assign w_ready[STAGES] = out_ready;
  assign in_ready        = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    aoi_pipe_stage #(
      .W (DW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .i_up_valid (w_valid[k]),
      .o_up_ready (w_ready[k]),
      .i_up_data  (w_data[k]),
      .o_dn_valid (w_valid[k+1]),
      .i_dn_ready (w_ready[k+1]),
      .o_dn_data  (w_data[k+1])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign out       = w_data[STAGES][CW];
  assign out_pairs = w_data[STAGES][CW-1:0];

endmodule

// File: tb/tb_aoi_reduce_pipe.sv
// tb_aoi_reduce_pipe: scoreboard bench for aoi_reduce_pipe.
// Driver pushes expected results; negedge monitor pops and compares.
module tb_aoi_reduce_pipe;

  localparam int P  = 4;
  localparam int S  = 3;
  localparam int CW = $clog2(P + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*P-1:0]  in_data = '0;
  logic [1:0]      mode = 2'd0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out;
  logic [CW-1:0]   out_pairs;

  aoi_reduce_pipe #(
    .PAIRS  (P),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_pairs (out_pairs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_out = -1;
  int last_out = -1;
  int last_acc = -1;
  logic [CW:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference: evaluate the spec rules pair by pair.
  function automatic logic [CW:0] model(logic [2*P-1:0] d, logic [1:0] m);
    int n;
    bit any;
    bit all;
    bit t;
    bit r;
    n = 0;
    any = 0;
    all = 1;
    for (int i = 0; i < P; i++) begin
      if (m < 2) t = d[2*i+1] && d[2*i];
      else       t = d[2*i+1] || d[2*i];
      n = n + int'(t);
      any = any | t;
      all = all & t;
    end
    case (m)
      2'd0:    r = !any;
      2'd1:    r = any;
      2'd2:    r = !all;
      default: r = all;
    endcase
    return {r, CW'(n)};
  endfunction

  task automatic step(input bit v, input logic [2*P-1:0] d,
                      input logic [1:0] m, input bit ro,
                      input logic [CW:0] e, output bit acc);
    in_valid = v;
    in_data = d;
    mode = m;
    out_ready = ro;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(e);
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit v, input bit ro, output bit acc);
    logic [2*P-1:0] d;
    logic [1:0] m;
    d = (2*P)'($urandom);
    m = 2'($urandom);
    step(v, d, m, ro, model(d, m), acc);
  endtask

  task automatic drain();
    int b;
    b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && b < 60) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        po = 1'b0;
  logic [CW-1:0] pp = '0;
  logic [CW:0] me;

  // Monitor: hold check on stall, scoreboard pop on transfer.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_out", int'(out), int'(po));
        chk("hold_pairs", int'(out_pairs), int'(pp));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", exp_q.size(), 1);
        end else begin
          me = exp_q.pop_front();
          chk("out", int'(out), int'(me[CW]));
          chk("out_pairs", int'(out_pairs), int'(me[CW-1:0]));
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end
      end
      pv = out_valid;
      pr = out_ready;
      po = out;
      pp = out_pairs;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n;
    int b;
    int acc0;
    bit v;
    bit ro;
    logic [CW:0] dir_e [4];
    // 8'hD3: pairs 11,00,01,11 -> AND terms 1001, OR terms 1101.
    dir_e[0] = {1'b0, 3'd2};
    dir_e[1] = {1'b1, 3'd2};
    dir_e[2] = {1'b1, 3'd3};
    dir_e[3] = {1'b0, 3'd3};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_out_pairs", int'(out_pairs), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hD3, 2'(i), 1'b1, dir_e[i], acc);
      chk("dir_acc", int'(acc), 1);
    end
    step(1'b1, 8'h03, 2'd0, 1'b1, {1'b0, 3'd1}, acc);
    chk("dir_acc", int'(acc), 1);
    step(1'b1, 8'h05, 2'd0, 1'b1, {1'b1, 3'd0}, acc);
    chk("dir_acc", int'(acc), 1);
    drain();

    first_out = -1;
    n = 0;
    acc0 = -1;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 1'b1, acc);
      n += int'(acc);
      if (i == 0) acc0 = last_acc;
    end
    chk("stream_acc", n, 10);
    drain();
    chk("latency", first_out - acc0, S);
    chk("throughput", last_out - first_out, 9);

    n = 0;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, acc);
      n += int'(acc);
      if (i >= S) chk("full_in_ready", int'(acc), 0);
    end
    chk("stall_acc", n, S);
    send(1'b1, 1'b1, acc);
    chk("full_simul_acc", int'(acc), 1);
    drain();

    n = 0;
    b = 0;
    while (n < 200 && b < 3000) begin
      v = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 2) != 0);
      send(v, ro, acc);
      n += int'(acc);
      b++;
    end
    chk("rand_acc", n, 200);
    drain();

    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out", int'(out), 0);
    chk("midrst_out_pairs", int'(out_pairs), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_empty", int'(out_valid), 0);
    @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 1'b1, acc);
      n += int'(acc);
    end
    chk("post_rst_acc", n, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
